// File: rtl/lp_serializer_scheduler.sv
// rtl/lp_serializer_scheduler.sv - round-robin two-requester word scheduler feeding lp_tree_serializer PAR_IN
// Optional post-reset link-training preamble is enabled by defining LP_SCHED_TRAIN_EN.
module lp_serializer_scheduler #(
  parameter int                    INPUTS_NUM  = 16,
  parameter int                    WORD_CYCLES = 8,
  parameter logic [INPUTS_NUM-1:0] IDLE_WORD   = 16'h0000,
  parameter logic [INPUTS_NUM-1:0] TRAIN_WORD  = 16'h00FF,
  parameter int                    TRAIN_WORDS = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  EN,
  input  logic                  REQ0_VALID,
  input  logic [INPUTS_NUM-1:0] REQ0_DATA,
  output logic                  REQ0_READY,
  input  logic                  REQ1_VALID,
  input  logic [INPUTS_NUM-1:0] REQ1_DATA,
  output logic                  REQ1_READY,
  output logic [INPUTS_NUM-1:0] PAR_OUT,
  output logic                  SLOT_STROBE,
  output logic [1:0]            GRANT,
  output logic                  TRAINING
);

  localparam int            CW   = $clog2(WORD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(WORD_CYCLES - 1);

  logic [CW-1:0]         cnt_q;
  logic                  rr_q, rr_d;
  logic [INPUTS_NUM-1:0] par_q, par_d;
  logic [1:0]            grant_q, grant_d;
  logic                  boundary, run, train_load;
  logic                  win0, win1;

  assign boundary = (cnt_q == LAST);

`ifdef LP_SCHED_TRAIN_EN
  typedef enum logic {S_TRAIN, S_RUN} state_t;
  localparam int             TCW   = $clog2(TRAIN_WORDS + 1);
  localparam logic [TCW-1:0] TLAST = TCW'(TRAIN_WORDS - 1);

  state_t         state_q;
  logic [TCW-1:0] tcnt_q;
  logic           training_q;

  assign run        = (state_q == S_RUN);
  assign train_load = boundary & EN & (state_q == S_TRAIN);
  assign TRAINING   = training_q;
`else
  logic unused_train;
  assign unused_train = ^TRAIN_WORDS;
  assign run        = 1'b1;
  assign train_load = 1'b0;
  assign TRAINING   = 1'b0;
`endif

  // Round robin only matters on a tie; a lone requester always wins.
  assign win0 = REQ0_VALID & (~REQ1_VALID | ~rr_q);
  assign win1 = REQ1_VALID & (~REQ0_VALID | rr_q);

  assign REQ0_READY  = boundary & run & EN & win0;
  assign REQ1_READY  = boundary & run & EN & win1;
  assign PAR_OUT     = par_q;
  assign GRANT       = grant_q;
  assign SLOT_STROBE = (cnt_q == '0);

  always_comb begin
    par_d   = IDLE_WORD;
    grant_d = 2'b00;
    rr_d    = rr_q;
    if (REQ0_READY) begin
      par_d   = REQ0_DATA;
      grant_d = 2'b01;
      rr_d    = 1'b1;
    end else if (REQ1_READY) begin
      par_d   = REQ1_DATA;
      grant_d = 2'b10;
      rr_d    = 1'b0;
    end else if (train_load) begin
      par_d   = TRAIN_WORD;
      grant_d = 2'b11;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q      <= '0;
      par_q      <= IDLE_WORD;
      grant_q    <= 2'b00;
      rr_q       <= 1'b0;
`ifdef LP_SCHED_TRAIN_EN
      state_q    <= S_TRAIN;
      tcnt_q     <= '0;
      training_q <= 1'b1;
`endif
    end else begin
      cnt_q <= boundary ? '0 : cnt_q + 1'b1;
      if (boundary) begin
        par_q   <= par_d;
        grant_q <= grant_d;
        rr_q    <= rr_d;
`ifdef LP_SCHED_TRAIN_EN
        // TRAINING covers the slot being loaded, including the last preamble word.
        training_q <= (state_q == S_TRAIN);
        if (train_load) begin
          tcnt_q <= tcnt_q + 1'b1;
          if (tcnt_q == TLAST) state_q <= S_RUN;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_lp_serializer_scheduler.sv
// tb/tb_lp_serializer_scheduler.sv - scoreboard bench for lp_serializer_scheduler
module tb_lp_serializer_scheduler;

  localparam int WC = 8;
`ifdef LP_SCHED_TRAIN_EN
  localparam logic TR = 1'b1;
`else
  localparam logic TR = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] w;
    logic [1:0]  g;
    logic        t;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        EN = 1'b0;
  logic        REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
  logic [15:0] REQ0_DATA = '0, REQ1_DATA = '0;
  logic        REQ0_READY, REQ1_READY, SLOT_STROBE, TRAINING;
  logic [15:0] PAR_OUT;
  logic [1:0]  GRANT;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc;
  logic mon_en = 1'b0;
  exp_t q[$];
  exp_t cur;

  lp_serializer_scheduler #(
    .INPUTS_NUM(16), .WORD_CYCLES(WC), .IDLE_WORD(16'h0000),
    .TRAIN_WORD(16'h00FF), .TRAIN_WORDS(4)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .EN(EN),
    .REQ0_VALID(REQ0_VALID), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
    .PAR_OUT(PAR_OUT), .SLOT_STROBE(SLOT_STROBE), .GRANT(GRANT), .TRAINING(TRAINING)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge CLK or negedge RESET_N)
    if (!RESET_N) cyc <= 0;
    else          cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (mon_en) begin
      check("slot_strobe", SLOT_STROBE, (cyc % WC) == 0);
      if (cyc % WC == 0) begin
        check("queue_has_entry", q.size() > 0, 1);
        if (q.size() > 0) cur = q.pop_front();
      end
      if (cyc % WC != WC - 1) check("ready_off_boundary", {REQ0_READY, REQ1_READY}, 0);
      check("par_out", PAR_OUT, cur.w);
      check("grant", GRANT, cur.g);
      check("training", TRAINING, cur.t);
    end
  end

  // Called just after the edge that starts a slot; EN is inverted for the first
  // three cycles to show that only the boundary value of EN matters.
  task automatic slot(input logic en, input logic v0, input logic [15:0] d0,
                      input logic v1, input logic [15:0] d1,
                      input logic [15:0] ew, input logic [1:0] eg,
                      input logic er0, input logic er1, input logic et = 1'b0);
    EN = ~en;
    REQ0_VALID = v0; REQ0_DATA = d0;
    REQ1_VALID = v1; REQ1_DATA = d1;
    repeat (3) @(posedge CLK);
    #1 EN = en;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("req0_ready", REQ0_READY, er0);
    check("req1_ready", REQ1_READY, er1);
    q.push_back(exp_t'({ew, eg, et}));
    @(posedge CLK);
    #1;
  endtask

  task automatic training_seq();
`ifdef LP_SCHED_TRAIN_EN
    for (int i = 0; i < 4; i++)
      slot(1, 1, 16'h1111, 0, 16'h0, 16'h00FF, 2'b11, 0, 0, 1);
    slot(1, 1, 16'h1111, 0, 16'h0, 16'h1111, 2'b01, 1, 0, 0);
    slot(1, 0, 16'h0, 1, 16'hBEEF, 16'hBEEF, 2'b10, 0, 1, 0);
`endif
  endtask

  task automatic release_reset();
    @(posedge CLK);
    #1 RESET_N = 1'b1;
    q.delete();
    q.push_back(exp_t'({16'h0000, 2'b00, TR}));
    mon_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1; EN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_par_out", PAR_OUT, 16'h0000);
    check("rst_grant", GRANT, 2'b00);
    check("rst_ready", {REQ0_READY, REQ1_READY}, 2'b00);
    check("rst_strobe", SLOT_STROBE, 1);
    check("rst_training", TRAINING, TR);
    release_reset();
    training_seq();

    slot(1, 0, 16'h0, 0, 16'h0, 16'h0000, 2'b00, 0, 0);
    slot(1, 0, 16'h0, 0, 16'h0, 16'h0000, 2'b00, 0, 0);

    slot(1, 1, 16'h1111, 1, 16'h2222, 16'h1111, 2'b01, 1, 0);
    slot(1, 1, 16'h1111, 1, 16'h2222, 16'h2222, 2'b10, 0, 1);
    slot(1, 1, 16'h1111, 1, 16'h2222, 16'h1111, 2'b01, 1, 0);
    slot(1, 1, 16'h1111, 1, 16'h2222, 16'h2222, 2'b10, 0, 1);

    slot(1, 0, 16'h0, 1, 16'hA5A5, 16'hA5A5, 2'b10, 0, 1);
    slot(1, 0, 16'h0, 1, 16'h5A5A, 16'h5A5A, 2'b10, 0, 1);
    slot(1, 0, 16'h0, 1, 16'hFFFF, 16'hFFFF, 2'b10, 0, 1);
    slot(1, 0, 16'h0, 0, 16'h0, 16'h0000, 2'b00, 0, 0);

    slot(1, 1, 16'h3333, 1, 16'h4444, 16'h3333, 2'b01, 1, 0);
    slot(0, 1, 16'h3333, 1, 16'h4444, 16'h0000, 2'b00, 0, 0);
    slot(1, 1, 16'h3333, 1, 16'h4444, 16'h4444, 2'b10, 0, 1);
    slot(1, 1, 16'h3333, 1, 16'h4444, 16'h3333, 2'b01, 1, 0);

    slot(1, 1, 16'h7777, 0, 16'h0, 16'h7777, 2'b01, 1, 0);
    repeat (3) @(posedge CLK);
    #2;
    mon_en = 1'b0;
    RESET_N = 1'b0;
    #1;
    check("midrst_par_out", PAR_OUT, 16'h0000);
    check("midrst_grant", GRANT, 2'b00);
    check("midrst_ready0", REQ0_READY, 0);
    check("midrst_strobe", SLOT_STROBE, 1);
    release_reset();
    training_seq();
    slot(1, 1, 16'h5555, 1, 16'h6666, 16'h5555, 2'b01, 1, 0);
    slot(1, 1, 16'h5555, 1, 16'h6666, 16'h6666, 2'b10, 0, 1);
    slot(1, 0, 16'h0, 0, 16'h0, 16'h0000, 2'b00, 0, 0);

    @(negedge CLK);
    #1 mon_en = 1'b0;
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lp_serializer_scheduler.md
# lp_serializer_scheduler

Word scheduler in front of `lp_tree_serializer`. It shares the serializer between two requesters using valid/ready handshakes and round-robin arbitration. It holds each granted word stable on the serializer's parallel input for exactly one word slot, and inserts idle words when no requester is ready. It sits in the `CLK` domain directly upstream of the serializer's `PAR_IN`. It can optionally emit a link-training preamble after reset.

## Interface
- `INPUTS_NUM`, 16, word width; equals the serializer `INPUTS_NUM`.
- `WORD_CYCLES`, 8, `CLK` cycles per word slot; ≥2.
- `IDLE_WORD`, 16'h0000, word driven when no grant.
- `TRAIN_WORD`, 16'h00FF, preamble word (used only with `LP_SCHED_TRAIN_EN`).
- `TRAIN_WORDS`, 4, preamble length in slots; ≥1.

Ports:
- `CLK` in 1: serializer word-domain clock.
- `RESET_N` in 1: asynchronous, active-low reset.
- `EN` in 1: scheduling enable.
- `REQ0_VALID` in 1: requester 0 has a word.
- `REQ0_DATA` in `INPUTS_NUM`: requester 0 word.
- `REQ0_READY` out 1: requester 0 word accepted this cycle.
- `REQ1_VALID`, `REQ1_DATA`, `REQ1_READY`: same as requester 0, for requester 1.
- `PAR_OUT` out `INPUTS_NUM`: to serializer `PAR_IN`.
- `SLOT_STROBE` out 1: high in the first cycle of each slot.
- `GRANT` out 2: owner of the current slot: 00 idle, 01 req0, 10 req1, 11 training.
- `TRAINING` out 1: preamble in progress.

## Operation
- Slot counter `cnt` runs 0..`WORD_CYCLES`-1 and wraps. It runs free from reset release and never stalls, so slot alignment is always preserved.
- Boundary cycle is `cnt == WORD_CYCLES-1`. The next slot's content is decided in this cycle and loaded on the following edge. Slot content is one of: a granted word, `TRAIN_WORD`, or `IDLE_WORD`.
- FSM states: `TRAIN` and `RUN`.
  - `TRAIN` (entered from reset only with the macro): each boundary loads `TRAIN_WORD` and increments the training count, but only while `EN`=1. After `TRAIN_WORDS` preamble slots the FSM moves to `RUN` at the next boundary.
  - `RUN`: arbitration is active.
- Arbitration in `RUN`, at a boundary with `EN`=1:
  - Only one `VALID` high: that requester wins.
  - Both high: the round-robin pointer `rr` decides. `rr`=0 selects req0.
  - After any grant, `rr` points to the other requester.
  - Neither high: load `IDLE_WORD`; `rr` is unchanged.
- Handshake:
  - `REQn_READY` = boundary & `RUN` & `EN` & the requester is the winner. It is combinational from the `VALID` inputs and `rr`, and never high without `VALID`.
  - Transfer happens when `VALID` & `READY`. `REQn_DATA` is captured into `PAR_OUT` on that edge.
  - Requesters must hold `VALID`/`DATA` until `READY`. `VALID` may deassert without transfer at any time.
- `EN`=0 at a boundary: no `READY` is asserted, `IDLE_WORD` is loaded, and the training count is frozen. `EN` changes between boundaries have no effect.
- `PAR_OUT` changes only on the edge leaving a boundary cycle and is stable for the whole slot.
- `GRANT` and `TRAINING` are registered alongside `PAR_OUT` and describe the current slot.

## Timing
- Reset values (asynchronous, on `RESET_N`=0):
  - `cnt`=0, `PAR_OUT`=`IDLE_WORD`, `GRANT`=00, `REQn_READY`=0, `rr`=0.
  - `SLOT_STROBE`=1 (since `cnt`=0).
  - With the macro: `TRAINING`=1, state `TRAIN`, training count 0.
  - Without the macro: `TRAINING`=0, state `RUN`.
- Reset mid-slot: the current word is dropped immediately. No partial handshake is possible because `READY` is combinational and gated by the registered state.
- Latency: a word accepted in boundary cycle t appears on `PAR_OUT` at t+1, together with `SLOT_STROBE`=1. It is held for `WORD_CYCLES` cycles.
- Peak throughput: one word per `WORD_CYCLES` cycles, shared. Under continuous dual requests each requester gets every other slot.
- First boundary after reset is cycle `WORD_CYCLES`-1. The first `PAR_OUT` update is at cycle `WORD_CYCLES`.

## Configuration
- `LP_SCHED_TRAIN_EN` defined:
  - Reset enters `TRAIN`, and the first `TRAIN_WORDS` enabled slots carry `TRAIN_WORD` with `GRANT`=11 and `TRAINING`=1.
  - No `READY` is asserted until `RUN`.
- `LP_SCHED_TRAIN_EN` undefined:
  - The `TRAIN` state and training counter are absent, and `TRAINING` is tied to 0.
  - Reset enters `RUN`, so arbitration is possible from the first boundary.

## Test plan
- Reset, no macro, `EN`=1, no `VALID`: `PAR_OUT`=0000 throughout, `SLOT_STROBE` high at cycles 0, 8, 16, …, `GRANT`=00.
- Macro on, `TRAIN_WORDS`=4, `REQ0_VALID` held high: `PAR_OUT`=00FF for slots 1–4, `TRAINING` falls at the start of slot 5, first `REQ0_READY` occurs in the boundary cycle ending slot 4.
- Both valid continuously, `REQ0_DATA`=1111, `REQ1_DATA`=2222: `PAR_OUT` alternates 1111, 2222, 1111, …, each held 8 cycles, and `READY` pulses alternate one per slot.
- Only `REQ1_VALID`, three words A5A5/5A5A/FFFF: the three words appear in consecutive slots, then `IDLE_WORD`; `REQ0_READY` never asserts.
- `EN` dropped mid-slot with both valid: the current word completes, then the next slot is `IDLE_WORD` with no `READY`. When `EN` rises, the grant resumes with the requester indicated by `rr`.
- `RESET_N` asserted at `cnt`=3 of a data slot: `PAR_OUT`=0000, `READY`=0, and `GRANT`=00 immediately (asynchronous). After release the slot counter restarts at 0.
